// File: rtl/msi_dir_pkg.sv
// msi_dir_pkg
// Shared definitions for the two-processor MSI home-node directory:
// geometry localparams, request and directory-state codes, the controller
// FSM state enum, and the power-on contents of memory and directory.
package msi_dir_pkg;

  localparam int NPROC = 2;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int NBLK  = 1 << AW;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10,
    REQ_WB    = 2'b11
  } reqType_e;

  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_S = 2'b01,
    DIR_E = 2'b10
  } dirState_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_INVAL,
    ST_FETCH,
    ST_REPLY
  } fsmState_e;

  function automatic logic [DW-1:0] memResetVal(input logic [AW-1:0] addr);
    case (addr)
      4'd1:    return 4'b0010;
      4'd2:    return 4'b0001;
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] dirResetState(input logic [AW-1:0] addr);
    case (addr)
      4'd1:    return DIR_E;
      4'd2:    return DIR_S;
      default: return DIR_U;
    endcase
  endfunction

  // Block 1 starts owned by P0, block 2 starts shared by P0.
  function automatic logic [NPROC-1:0] dirResetSharers(input logic [AW-1:0] addr);
    case (addr)
      4'd1, 4'd2: return 2'b01;
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/msi_dir_arbiter.sv
// msi_dir_arbiter
// Two-way round-robin arbiter. A lone requester is granted directly; when
// both request, the one not granted last wins. The last-grant register only
// advances when the grant is actually taken (en_i high).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i          per-processor request (already masked by the caller)
//   en_i           grant is consumed this cycle
//   gntValid_o     some request is present
//   gntIdx_o       index of the granted processor
module msi_dir_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gntValid_o,
  output logic       gntIdx_o
);

  logic lastGnt_q, lastGnt_d;

  always_comb begin
    gntValid_o = |req_i;
    if (req_i == 2'b11) gntIdx_o = ~lastGnt_q;
    else                gntIdx_o = req_i[1];
    lastGnt_d = (en_i && gntValid_o) ? gntIdx_o : lastGnt_q;
  end

  // Reset as if P1 was granted last so that P0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lastGnt_q <= 1'b1;
    else         lastGnt_q <= lastGnt_d;
  end

endmodule

// File: rtl/msi_directory.sv
// msi_directory
// Home-node directory controller for a two-cache MSI protocol. Serves
// ReadMiss/WriteMiss/WriteBack requests, keeps per-block directory state and
// backing memory, and issues invalidate / fetch commands to remote caches.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   reqValid_i/Type/Addr/Data per-processor request lanes {P1,P0}
//   reqAck_o, respValid_o    one-cycle completion / data-valid to requester
//   respData_o               block data (0 when respValid_o is low)
//   invReq_o, fetchReq_o     level commands to remote caches, cmdAddr_o addr
//   invAck_i, fetchValid_i   remote responses, fetchData_i owner data {P1,P0}
//   busy_o                   controller not in IDLE
module msi_directory
  import msi_dir_pkg::*;
(
  input  logic [0:0]          clk_i,
  input  logic                rst_ni,
  input  logic [NPROC-1:0]    reqValid_i,
  input  logic [2*NPROC-1:0]  reqType_i,
  input  logic [NPROC*AW-1:0] reqAddr_i,
  input  logic [NPROC*DW-1:0] reqData_i,
  output logic [NPROC-1:0]    reqAck_o,
  output logic [NPROC-1:0]    respValid_o,
  output logic [DW-1:0]       respData_o,
  output logic [NPROC-1:0]    invReq_o,
  output logic [NPROC-1:0]    fetchReq_o,
  output logic [AW-1:0]       cmdAddr_o,
  input  logic [NPROC-1:0]    invAck_i,
  input  logic [NPROC-1:0]    fetchValid_i,
  input  logic [NPROC*DW-1:0] fetchData_i,
  output logic                busy_o
);

  fsmState_e state_q, state_d;

  logic          reqIdx_q;
  logic [1:0]    reqType_q;
  logic [AW-1:0] reqAddr_q;
  logic [DW-1:0] reqData_q;

  logic [DW-1:0]    mem_q        [NBLK];
  logic [1:0]       dirState_q   [NBLK];
  logic [NPROC-1:0] dirSharers_q [NBLK];

  logic [NPROC-1:0] invSeen_q;
  logic [NPROC-1:0] reqAck_q, reqAck_d, respValid_q, respValid_d;
  logic [NPROC-1:0] invReq_q, invReq_d, fetchReq_q, fetchReq_d;
  logic [DW-1:0]    respData_q, respData_d;
  logic [AW-1:0]    cmdAddr_q, cmdAddr_d;

  logic gntValid, gntIdx;
  logic [NPROC-1:0] reqOneHot, curSharers, otherSharers;
  logic [1:0]       curState;
  logic             addrZero, isMiss, isOwner, needFetch, needInval;
  logic             invDone, fetchDone;
  logic [DW-1:0]    ownerData;

  // A requester whose ack is on the wire is still holding ReqValid for the
  // request just completed; mask it so it is not served twice.
  msi_dir_arbiter uArbiter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (reqValid_i & ~reqAck_q),
    .en_i       (state_q == ST_IDLE),
    .gntValid_o (gntValid),
    .gntIdx_o   (gntIdx)
  );

  always_comb begin
    reqOneHot    = reqIdx_q ? 2'b10 : 2'b01;
    curState     = dirState_q[reqAddr_q];
    curSharers   = dirSharers_q[reqAddr_q];
    otherSharers = curSharers & ~reqOneHot;
    addrZero     = (reqAddr_q == '0);
    isMiss       = (reqType_q == REQ_READ) || (reqType_q == REQ_WRITE);
    isOwner      = (curState == DIR_E) && (curSharers == reqOneHot);
    needFetch    = !addrZero && isMiss && (curState == DIR_E) && (otherSharers != '0);
    needInval    = !addrZero && (reqType_q == REQ_WRITE) && (curState == DIR_S) &&
                   (otherSharers != '0);
    invDone      = ((invSeen_q | invAck_i) & invReq_q) == invReq_q;
    fetchDone    = |(fetchValid_i & fetchReq_q);
    ownerData    = fetchReq_q[1] ? fetchData_i[2*DW-1:DW] : fetchData_i[DW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gntValid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (needFetch)      state_d = ST_FETCH;
        else if (needInval) state_d = ST_INVAL;
        else                state_d = ST_REPLY;
      end
      ST_INVAL:  if (invDone)   state_d = ST_REPLY;
      ST_FETCH:  if (fetchDone) state_d = ST_REPLY;
      ST_REPLY:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. Commands are raised on leaving
  // LOOKUP and held until the remote side has answered.
  always_comb begin
    reqAck_d    = '0;
    respValid_d = '0;
    respData_d  = '0;
    invReq_d    = '0;
    fetchReq_d  = '0;
    cmdAddr_d   = '0;
    case (state_q)
      ST_LOOKUP: begin
        if (needFetch) begin
          fetchReq_d = otherSharers;
          cmdAddr_d  = reqAddr_q;
        end else if (needInval) begin
          invReq_d  = otherSharers;
          cmdAddr_d = reqAddr_q;
        end
      end
      ST_INVAL: if (!invDone) begin
        invReq_d  = invReq_q;
        cmdAddr_d = cmdAddr_q;
      end
      ST_FETCH: if (!fetchDone) begin
        fetchReq_d = fetchReq_q;
        cmdAddr_d  = cmdAddr_q;
      end
      ST_REPLY: begin
        reqAck_d = reqOneHot;
        if (isMiss) begin
          respValid_d = reqOneHot;
          respData_d  = addrZero ? '0 : mem_q[reqAddr_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reqAck_q    <= '0;
      respValid_q <= '0;
      respData_q  <= '0;
      invReq_q    <= '0;
      fetchReq_q  <= '0;
      cmdAddr_q   <= '0;
      invSeen_q   <= '0;
      reqIdx_q    <= 1'b0;
      reqType_q   <= '0;
      reqAddr_q   <= '0;
      reqData_q   <= '0;
    end else begin
      reqAck_q    <= reqAck_d;
      respValid_q <= respValid_d;
      respData_q  <= respData_d;
      invReq_q    <= invReq_d;
      fetchReq_q  <= fetchReq_d;
      cmdAddr_q   <= cmdAddr_d;
      if (state_q == ST_IDLE && gntValid) begin
        reqIdx_q  <= gntIdx;
        reqType_q <= gntIdx ? reqType_i[3:2] : reqType_i[1:0];
        reqAddr_q <= gntIdx ? reqAddr_i[2*AW-1:AW] : reqAddr_i[AW-1:0];
        reqData_q <= gntIdx ? reqData_i[2*DW-1:DW] : reqData_i[DW-1:0];
      end
      // Acks from caches that were never targeted are dropped here.
      if (state_q == ST_LOOKUP)     invSeen_q <= '0;
      else if (state_q == ST_INVAL) invSeen_q <= (invSeen_q | invAck_i) & invReq_q;
    end
  end

  // Memory and directory. A write-back only takes effect from the current
  // exclusive owner; miss bookkeeping is applied in REPLY, after any fetch,
  // so a downgraded owner remains a sharer on a ReadMiss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NBLK; i++) begin
        mem_q[i]        <= memResetVal(AW'(i));
        dirState_q[i]   <= dirResetState(AW'(i));
        dirSharers_q[i] <= dirResetSharers(AW'(i));
      end
    end else begin
      case (state_q)
        ST_LOOKUP: if (reqType_q == REQ_WB && !addrZero && isOwner) begin
          mem_q[reqAddr_q]        <= reqData_q;
          dirState_q[reqAddr_q]   <= DIR_U;
          dirSharers_q[reqAddr_q] <= '0;
        end
        ST_FETCH: if (fetchDone) mem_q[reqAddr_q] <= ownerData;
        ST_REPLY: if (!addrZero) begin
          if (reqType_q == REQ_READ) begin
            dirState_q[reqAddr_q]   <= DIR_S;
            dirSharers_q[reqAddr_q] <= curSharers | reqOneHot;
          end else if (reqType_q == REQ_WRITE) begin
            dirState_q[reqAddr_q]   <= DIR_E;
            dirSharers_q[reqAddr_q] <= reqOneHot;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reqAck_o    = reqAck_q;
    respValid_o = respValid_q;
    respData_o  = respData_q;
    invReq_o    = invReq_q;
    fetchReq_o  = fetchReq_q;
    cmdAddr_o   = cmdAddr_q;
    busy_o      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_msi_directory.sv
// tb_msi_directory
// Self-checking bench for msi_directory: directed protocol scenarios then
// randomized single requests, compared against a block-level model of the
// directory (per-address state, sharer set and memory word) and of the
// round-robin grant order.
module tb_msi_directory;

  logic       clk = 1'b0;
  logic       rstN;
  logic [1:0] reqValid;
  logic [3:0] reqType;
  logic [7:0] reqAddr, reqData;
  logic [1:0] reqAck, respValid;
  logic [3:0] respData;
  logic [1:0] invReq, fetchReq;
  logic [3:0] cmdAddr;
  logic [1:0] invAck, fetchValid;
  logic [7:0] fetchData;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [3:0] mMem [16];
  logic [1:0] mSt  [16];
  logic [1:0] mSh  [16];
  int         lastGrant;

  always #5 clk = ~clk;

  msi_directory dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .reqValid_i   (reqValid),
    .reqType_i    (reqType),
    .reqAddr_i    (reqAddr),
    .reqData_i    (reqData),
    .reqAck_o     (reqAck),
    .respValid_o  (respValid),
    .respData_o   (respData),
    .invReq_o     (invReq),
    .fetchReq_o   (fetchReq),
    .cmdAddr_o    (cmdAddr),
    .invAck_i     (invAck),
    .fetchValid_i (fetchValid),
    .fetchData_i  (fetchData),
    .busy_o       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Power-on contents: block 1 exclusive at P0, block 2 shared by P0.
  task automatic modelReset;
    for (int i = 0; i < 16; i++) begin
      mMem[i] = 4'd0;
      mSt[i]  = 2'd0;
      mSh[i]  = 2'd0;
    end
    mMem[1] = 4'b0010; mSt[1] = 2'd2; mSh[1] = 2'b01;
    mMem[2] = 4'b0001; mSt[2] = 2'd1; mSh[2] = 2'b01;
    lastGrant = 1;
  endtask

  task automatic checkEntry(input string tag, input int a);
    checkOutput($sformatf("%s mem[%0d]", tag, a), 32'(dut.mem_q[a]), 32'(mMem[a]));
    checkOutput($sformatf("%s dirState[%0d]", tag, a), 32'(dut.dirState_q[a]), 32'(mSt[a]));
    checkOutput($sformatf("%s sharers[%0d]", tag, a), 32'(dut.dirSharers_q[a]), 32'(mSh[a]));
  endtask

  task automatic checkDirectory(input string tag);
    for (int i = 0; i < 16; i++) checkEntry(tag, i);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " outputs"},
                32'({reqAck, respValid, respData, invReq, fetchReq, cmdAddr, busy}), 32'd0);
  endtask

  task automatic doReset;
    rstN = 1'b0;
    reqValid = '0; invAck = '0; fetchValid = '0;
    reqType = '0; reqAddr = '0; reqData = '0; fetchData = '0;
    modelReset();
    tick();
    tick();
    checkQuiet("reset");
    checkDirectory("reset");
    rstN = 1'b1;
    tick();
  endtask

  // One request from processor p, with the bench acting as both caches:
  // commands are answered dly cycles after they appear; noise drives stray
  // acks/strobes that must be ignored.
  task automatic applyStimulus(input int p, input logic [1:0] typ, input int addr,
                               input logic [3:0] wdata, input logic [3:0] fval,
                               input int dly, input bit noise);
    logic [1:0] pm, expInv, expFetch, expRV, newSt, newSh;
    logic [3:0] expData, newMem;
    int         expLat, ackAt, cmdAt;
    pm       = (p == 1) ? 2'b10 : 2'b01;
    expInv   = 2'b00;
    expFetch = 2'b00;
    newMem   = mMem[addr];
    newSt    = mSt[addr];
    newSh    = mSh[addr];
    if (addr != 0) begin
      if (typ != 2'b11 && mSt[addr] == 2'd2 && mSh[addr] != pm) expFetch = mSh[addr];
      if (typ == 2'b10 && mSt[addr] == 2'd1) expInv = mSh[addr] & ~pm;
      if (expFetch != 0) newMem = fval;
      if (typ == 2'b11 && mSt[addr] == 2'd2 && mSh[addr] == pm) begin
        newMem = wdata; newSt = 2'd0; newSh = 2'b00;
      end
      if (typ == 2'b01) begin newSt = 2'd1; newSh = newSh | pm; end
      if (typ == 2'b10) begin newSt = 2'd2; newSh = pm; end
    end
    expLat  = ((expInv | expFetch) != 0) ? 4 + dly : 3;
    expRV   = (typ == 2'b11) ? 2'b00 : pm;
    expData = (typ == 2'b11 || addr == 0) ? 4'd0 : newMem;

    reqType = 4'($urandom);
    reqAddr = 8'($urandom);
    reqData = 8'($urandom);
    reqType[2*p +: 2] = typ;
    reqAddr[4*p +: 4] = 4'(addr);
    reqData[4*p +: 4] = wdata;
    reqValid = pm;
    ackAt = -1;
    cmdAt = -1;
    for (int c = 1; c <= 60 && ackAt < 0; c++) begin
      tick();
      invAck = '0;
      fetchValid = '0;
      if ((invReq | fetchReq) != 0 && cmdAt < 0) begin
        cmdAt = c;
        checkOutput("cmdStart", 32'(c), 32'd2);
        checkOutput("invReq", 32'(invReq), 32'(expInv));
        checkOutput("fetchReq", 32'(fetchReq), 32'(expFetch));
        checkOutput("cmdAddr", 32'(cmdAddr), 32'(addr));
      end
      if (cmdAt > 0 && c == cmdAt + dly) begin
        invAck = invReq;
        fetchValid = fetchReq;
        fetchData = 8'($urandom);
        fetchData[4*int'(expFetch[1]) +: 4] = fval;
      end else if (noise) begin
        invAck = 2'($urandom) & ~expInv;
        fetchValid = 2'($urandom) & ~expFetch;
        fetchData = 8'($urandom);
      end
      if (reqAck != 0) begin
        ackAt = c;
        checkOutput("latency", 32'(c), 32'(expLat));
        checkOutput("reqAck", 32'(reqAck), 32'(pm));
        checkOutput("respValid", 32'(respValid), 32'(expRV));
        checkOutput("respData", 32'(respData), 32'(expData));
      end else begin
        checkOutput("respIdle", 32'({respValid, respData}), 32'd0);
      end
    end
    if (ackAt < 0) checkOutput("ackTimeout", 32'd0, 32'd1);
    tick();
    invAck = '0;
    fetchValid = '0;
    checkOutput("noRegrant", 32'({busy, reqAck}), 32'd0);
    reqValid = '0;
    lastGrant = p;
    mMem[addr] = newMem;
    mSt[addr]  = newSt;
    mSh[addr]  = newSh;
    checkEntry("txn", addr);
  endtask

  // Both processors issue ReadMiss in the same cycle to blocks needing no
  // remote command; grant order must follow the round-robin rule.
  task automatic contend(input int a0, input int a1);
    int         w, l, c;
    logic [1:0] pend, prevAck, wm, lm;
    w  = 1 - lastGrant;
    l  = lastGrant;
    wm = (w == 1) ? 2'b10 : 2'b01;
    lm = (l == 1) ? 2'b10 : 2'b01;
    reqType  = 4'b0101;
    reqAddr  = {4'(a1), 4'(a0)};
    reqData  = '0;
    reqValid = 2'b11;
    pend = 2'b11;
    prevAck = 2'b00;
    c = 0;
    while (pend != 0 && c < 20) begin
      tick();
      c++;
      reqValid = reqValid & ~prevAck;
      prevAck = reqAck;
      if (reqAck != 0) begin
        if (pend == 2'b11) begin
          checkOutput("firstGrant", 32'(reqAck), 32'(wm));
          checkOutput("firstAt", 32'(c), 32'd3);
          checkOutput("firstData", 32'(respData), 32'(mMem[w == 1 ? a1 : a0]));
        end else begin
          checkOutput("secondGrant", 32'(reqAck), 32'(lm));
          checkOutput("secondAt", 32'(c), 32'd6);
          checkOutput("secondData", 32'(respData), 32'(mMem[l == 1 ? a1 : a0]));
        end
        pend = pend & ~reqAck;
      end
    end
    if (pend != 0) checkOutput("contendTimeout", 32'(pend), 32'd0);
    tick();
    checkOutput("contendIdle", 32'({busy, reqAck}), 32'd0);
    reqValid = '0;
    mSt[a0] = 2'd1; mSh[a0] = mSh[a0] | 2'b01;
    mSt[a1] = 2'd1; mSh[a1] = mSh[a1] | 2'b10;
    lastGrant = l;
    checkEntry("contend", a0);
    checkEntry("contend", a1);
  endtask

  initial begin
    bit seen;
    doReset();

    applyStimulus(1, 2'b01, 3, 4'd0, 4'd0, 0, 1'b0);
    applyStimulus(1, 2'b01, 1, 4'd0, 4'b0010, 1, 1'b1);
    checkOutput("plan sharers[1]", 32'(dut.dirSharers_q[1]), 32'd3);
    applyStimulus(1, 2'b10, 2, 4'd0, 4'd0, 2, 1'b1);
    checkOutput("plan owner[2]", 32'({dut.dirState_q[2], dut.dirSharers_q[2]}), 32'b1010);

    contend(5, 6);
    applyStimulus(0, 2'b01, 9, 4'd0, 4'd0, 0, 1'b0);
    contend(7, 8);

    doReset();
    applyStimulus(0, 2'b11, 1, 4'b0111, 4'd0, 0, 1'b0);
    checkOutput("plan wb mem[1]", 32'(dut.mem_q[1]), 32'b0111);
    applyStimulus(1, 2'b11, 1, 4'b1010, 4'd0, 0, 1'b0);
    applyStimulus(0, 2'b01, 0, 4'd0, 4'd0, 0, 1'b0);
    applyStimulus(1, 2'b10, 0, 4'd5, 4'd0, 0, 1'b0);

    doReset();
    applyStimulus(0, 2'b10, 3, 4'd0, 4'd0, 0, 1'b0);
    reqType  = 4'b0100;
    reqAddr  = 8'h10;
    reqValid = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (fetchReq != 0) seen = 1'b1;
    end
    checkOutput("midFetch fetchReq", 32'(fetchReq), 32'b01);
    checkOutput("midFetch cmdAddr", 32'(cmdAddr), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    reqValid = '0;
    checkQuiet("midFetchReset");
    modelReset();
    checkDirectory("midFetchReset");
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("afterReset busy", 32'(busy), 32'd0);

    for (int n = 0; n < 120; n++) begin
      applyStimulus(int'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
                    int'($urandom_range(0, 5)), 4'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)), 1'b1);
    end
    checkDirectory("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msi_directory.md
# msi_directory

Home-node directory controller for the two-processor MSI directory protocol: the responder end of the L1 cache controllers' ReadMiss/WriteMiss/WriteBack requests. It arbitrates between the two caches and holds per-block directory state plus backing memory. It also issues invalidate and fetch (forced write-back) commands to remote caches, then replies with block data. It sits between the L1 controllers and main memory, one instance per home node.

## Interface
- NPROC, 2, number of caches served (fixed at 2; bit i = processor Pi)
- AW, 4, address/tag width; address 0 means "empty"
- DW, 4, data width
- Clock  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReqValid  in  2  per-processor request, held high until ReqAck
- ReqType  in  4  {P1,P0} 2-bit codes: 01 ReadMiss, 10 WriteMiss, 11 WriteBack
- ReqAddr  in  8  {P1,P0} block address
- ReqData  in  8  {P1,P0} write-back data (WriteBack only)
- ReqAck  out  2  one-cycle completion pulse to requester
- RespValid  out  2  one-cycle data-valid, coincident with ReqAck (misses only)
- RespData  out  4  block data for the granted requester
- InvReq  out  2  level invalidate command per target cache
- FetchReq  out  2  level fetch-and-downgrade/invalidate command to owner
- CmdAddr  out  4  address for InvReq/FetchReq
- InvAck  in  2  one-cycle invalidate acknowledge
- FetchValid  in  2  one-cycle owner data-return strobe
- FetchData  in  8  {P1,P0} owner data
- Busy  out  1  high in every state except IDLE

## Operation
- Directory entry per address (16): state U=00 uncached, S=01 shared, E=10 exclusive; Sharers[1:0]; owner = the single set Sharers bit when E. Memory Mem[16] of DW bits.
- Reset values: Mem[1]=0010, Mem[2]=0001, other Mem 0; Dir[1]=E owner P0; Dir[2]=S Sharers=01; others U/00. All outputs 0, FSM IDLE.
- FSM: IDLE, LOOKUP, INVAL, FETCH, REPLY.
- IDLE: if any ReqValid, grant round-robin (P0 first after reset; on contention, the processor not granted last wins); latch type/addr/data -> LOOKUP.
- LOOKUP decisions:
  - ReadMiss: U or S -> REPLY; E with owner ≠ requester -> FETCH (owner downgrades to S); E owned by requester -> REPLY from Mem.
  - WriteMiss: U -> REPLY; S with sharers other than requester -> INVAL those; otherwise REPLY; E with other owner -> FETCH (owner invalidates).
  - WriteBack from current E owner: Mem=ReqData, Dir=U, Sharers=00 -> REPLY (no RespValid). WriteBack from non-owner: no update, REPLY.
  - Address 0: REPLY with RespData=0, no directory or Mem change.
- INVAL: InvReq bits held for all targets; InvAck latched per bit; when all targets acked -> REPLY.
- FETCH: FetchReq[owner] held until FetchValid[owner]; Mem[addr]=FetchData[owner] -> REPLY.
- REPLY (one cycle): ReqAck[g]=1; RespValid[g]=1 and RespData=Mem[addr] for misses. Directory update: ReadMiss -> S, Sharers |= requester (a downgraded owner stays sharer); WriteMiss -> E, Sharers = requester only. -> IDLE.
- InvAck/FetchValid outside INVAL/FETCH, or from non-targets, are ignored.

## Timing
- All outputs registered; RespData is 0 when RespValid is low.
- Uncontended miss hitting U/S: ReqValid sampled at edge 0; ReqAck/RespValid high in cycle after edge 2 (2-cycle latency).
- INVAL/FETCH add 1 cycle plus remote response time; no timeout.
- Requester deasserts ReqValid on the edge ending its ReqAck cycle; it is never re-granted for the same request.
- Simultaneous ReqValid: one granted; the other waits, served on the next IDLE.
- Reset_n low at any time: immediate return to reset values, including mid-INVAL/FETCH; any pending command is dropped.

## Structure
- Package msi_dir_pkg: request codes (01/10/11), directory state codes, FSM state enum, Mem/Dir reset constants.
- Sub-module msi_dir_arbiter: 2-way round-robin grant with last-grant register.

## Test plan
- Reset, P1 ReadMiss addr 0011 -> RespValid[1], RespData 0000, Dir[3]=S, Sharers=10, at 2-cycle latency.
- P1 ReadMiss addr 0001 (E owner P0) -> FetchReq=01, CmdAddr 0001; P0 returns FetchValid with 0010 -> RespData 0010, Dir[1]=S, Sharers=11.
- P1 WriteMiss addr 0010 (S by P0) -> InvReq=01; after InvAck[0] -> ReqAck[1], Dir[2]=E owner P1.
- P0 and P1 request same cycle twice -> grants P0, P1, P1, P0 order per round-robin.
- P0 WriteBack addr 0001 data 0111 -> ReqAck[0], no RespValid, Mem[1]=0111, Dir[1]=U; repeat from P1 -> no change.
- Reset_n pulsed during FETCH -> FetchReq drops immediately, Busy 0, Dir/Mem back to reset values.
